// File: rtl/cpsr_flag_writer_pkg.sv
// Shared types for the CPSR flag producer: condition codes, flag bit
// positions and the sequencing states.
package cpsr_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/cpsr_flag_writer_if.sv
// Execute-stage instruction signals plus the CPSR write/read port.
// master = pipeline/CPSR side, slave = the flag writer.
interface cpsr_flag_writer_if #(
    parameter int bus = 4
);
    logic           instr_valid;
    logic           flush;
    logic [3:0]     cond;
    logic [bus-1:0] flag_wmask;
    logic [bus-1:0] alu_flags;
    logic [bus-1:0] cpsr_q;
    logic           instr_ready;
    logic           cond_ex;
    logic [bus-1:0] flags_cur;
    logic [bus-1:0] cpsr_d;
    logic           cpsr_we;

    modport master (
        output instr_valid, flush, cond, flag_wmask, alu_flags, cpsr_q,
        input  instr_ready, cond_ex, flags_cur, cpsr_d, cpsr_we
    );

    modport slave (
        input  instr_valid, flush, cond, flag_wmask, alu_flags, cpsr_q,
        output instr_ready, cond_ex, flags_cur, cpsr_d, cpsr_we
    );
endinterface

// File: rtl/cpsr_flag_writer_cond_check.sv
// ARMv4 condition-field evaluator; purely combinational so the branch
// unit can share it.
module cond_check
    import cpsr_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond_e'(cond))
            EQ: pass = z;
            NE: pass = !z;
            CS: pass = c;
            CC: pass = !c;
            MI: pass = n;
            PL: pass = !n;
            VS: pass = v;
            VC: pass = !v;
            HI: pass = c && !z;
            LS: pass = !c || z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = !z && (n == v);
            LE: pass = z || (n != v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpsr_flag_writer.sv
// Drives the CPSR write port from the execute stage: condition check,
// masked flag merge and a one-entry bypass of the write in flight.
//
// state | meaning
// RESET | rst_n low; no write, not ready
// INIT  | first cycle after release; writes 0 into the CPSR
// RUN   | accepting instructions until next reset
module cpsr_flag_writer
    import cpsr_pkg::*;
#(
    parameter int bus = 4
) (
    input  logic clk,
    input  logic rst_n,
    cpsr_flag_writer_if.slave bus_if
);
    state_e         state, state_nxt;
    logic           cpsr_we_q, we_nxt;
    logic [bus-1:0] cpsr_d_q, d_nxt;
    logic [bus-1:0] flags_cur;
    logic [bus-1:0] merged;
    logic           pass;
    logic           accept;

    // The write presented this cycle lands in the CPSR only at the
    // falling edge, so readers must see it via cpsr_d until then.
    assign flags_cur = cpsr_we_q ? cpsr_d_q : bus_if.cpsr_q;

    cond_check u_cond_check (
        .cond  (bus_if.cond),
        .flags (flags_cur[FLAG_N:FLAG_V]),
        .pass  (pass)
    );

    assign accept = (state == RUN) && bus_if.instr_valid && !bus_if.flush;
    assign merged = (bus_if.alu_flags & bus_if.flag_wmask)
                  | (flags_cur & ~bus_if.flag_wmask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RESET;
            cpsr_we_q <= 1'b0;
            cpsr_d_q  <= '0;
        end else begin
            state     <= state_nxt;
            cpsr_we_q <= we_nxt;
            cpsr_d_q  <= d_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        d_nxt     = cpsr_d_q;
        unique case (state)
            RESET: begin
                state_nxt = INIT;
                we_nxt    = 1'b1;
                d_nxt     = '0;
            end
            INIT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (accept && pass && (|bus_if.flag_wmask)) begin
                    we_nxt = 1'b1;
                    d_nxt  = merged;
                end
            end
            default: begin
                state_nxt = RESET;
            end
        endcase
    end

    assign bus_if.instr_ready = (state == RUN);
    assign bus_if.cond_ex     = pass;
    assign bus_if.flags_cur   = flags_cur;
    assign bus_if.cpsr_d      = cpsr_d_q;
    assign bus_if.cpsr_we     = cpsr_we_q;
endmodule

// File: tb/tb_cpsr_flag_writer.sv
// Directed bench for cpsr_flag_writer with a behavioural CPSR that
// captures datain on the falling edge when CPSR_WE is high.
module tb_cpsr_flag_writer;
    import cpsr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] cpsr_mdl = 4'b1010;

    cpsr_flag_writer_if #(.bus(4)) bus_if ();

    cpsr_flag_writer #(.bus(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.cpsr_we) cpsr_mdl <= bus_if.cpsr_d;
    end
    assign bus_if.cpsr_q = cpsr_mdl;

    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp_pass;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] c,
                         input logic [3:0] m, input logic [3:0] a);
        bus_if.instr_valid = v;
        bus_if.flush       = f;
        bus_if.cond        = c;
        bus_if.flag_wmask  = m;
        bus_if.alu_flags   = a;
    endtask

    // Unconditional full-mask write, then idle; flags visible via bypass.
    task automatic write_flags(input logic [3:0] f);
        drive(1'b1, 1'b0, AL, 4'b1111, f);
        tick();
        drive(1'b0, 1'b0, AL, 4'b0000, 4'b0000);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, AL, 4'b0000, 4'b0000);

        // Condition table: flags, cond, expected pass
        vecs.push_back({4'b0100, EQ, 1'b1});
        vecs.push_back({4'b0100, NE, 1'b0});
        vecs.push_back({4'b0100, CS, 1'b0});
        vecs.push_back({4'b0100, CC, 1'b1});
        vecs.push_back({4'b0100, MI, 1'b0});
        vecs.push_back({4'b0100, PL, 1'b1});
        vecs.push_back({4'b0100, VS, 1'b0});
        vecs.push_back({4'b0100, VC, 1'b1});
        vecs.push_back({4'b0100, HI, 1'b0});
        vecs.push_back({4'b0100, LS, 1'b1});
        vecs.push_back({4'b0100, GE, 1'b1});
        vecs.push_back({4'b0100, LT, 1'b0});
        vecs.push_back({4'b0100, GT, 1'b0});
        vecs.push_back({4'b0100, LE, 1'b1});
        vecs.push_back({4'b0100, AL, 1'b1});
        vecs.push_back({4'b0100, NV, 1'b0});
        vecs.push_back({4'b1001, GE, 1'b1});
        vecs.push_back({4'b1001, GT, 1'b1});
        vecs.push_back({4'b1001, LE, 1'b0});
        vecs.push_back({4'b1001, MI, 1'b1});
        vecs.push_back({4'b1001, VS, 1'b1});
        vecs.push_back({4'b0010, HI, 1'b1});
        vecs.push_back({4'b0010, LS, 1'b0});
        vecs.push_back({4'b0010, CS, 1'b1});
        vecs.push_back({4'b1000, GE, 1'b0});
        vecs.push_back({4'b1000, LT, 1'b1});
        vecs.push_back({4'b1000, LE, 1'b1});
        vecs.push_back({4'b1000, NE, 1'b1});

        // Reset / init
        repeat (3) tick();
        check("rst_we",    {3'b0, bus_if.cpsr_we},     4'd0);
        check("rst_d",     bus_if.cpsr_d,              4'd0);
        check("rst_ready", {3'b0, bus_if.instr_ready}, 4'd0);
        rst_n = 1'b1;
        tick();
        check("init_we",    {3'b0, bus_if.cpsr_we},     4'd1);
        check("init_d",     bus_if.cpsr_d,              4'd0);
        check("init_ready", {3'b0, bus_if.instr_ready}, 4'd0);
        tick();
        check("run_ready", {3'b0, bus_if.instr_ready}, 4'd1);
        check("run_we",    {3'b0, bus_if.cpsr_we},     4'd0);
        check("run_cpsr_q", bus_if.cpsr_q,             4'd0);

        // Condition sweep
        foreach (vecs[i]) begin
            write_flags(vecs[i].flags);
            bus_if.cond = vecs[i].cond;
            #1;
            check($sformatf("cond_flags_%0d", i), bus_if.flags_cur, vecs[i].flags);
            check($sformatf("cond_ex_%0d", i), {3'b0, bus_if.cond_ex}, {3'b0, vecs[i].exp_pass});
        end

        // Back-to-back bypass
        write_flags(4'b0000);
        tick();
        check("bb_base", bus_if.cpsr_q, 4'b0000);
        drive(1'b1, 1'b0, AL, 4'b1111, 4'b0110);
        tick();
        check("bb_we", {3'b0, bus_if.cpsr_we}, 4'd1);
        check("bb_d",  bus_if.cpsr_d,          4'b0110);
        drive(1'b1, 1'b0, EQ, 4'b0000, 4'b0000);
        #1;
        check("bb_flags_cur", bus_if.flags_cur,          4'b0110);
        check("bb_beq",       {3'b0, bus_if.cond_ex},    4'd1);
        tick();
        check("bb_cpsr_q", bus_if.cpsr_q,           4'b0110);
        check("bb_we_off", {3'b0, bus_if.cpsr_we},  4'd0);

        // Partial mask chain
        write_flags(4'b1001);
        tick();
        check("pm_base", bus_if.flags_cur, 4'b1001);
        drive(1'b1, 1'b0, AL, 4'b1110, 4'b0110);
        tick();
        check("pm1_we", {3'b0, bus_if.cpsr_we}, 4'd1);
        check("pm1_d",  bus_if.cpsr_d,          4'b0111);
        drive(1'b1, 1'b0, AL, 4'b0001, 4'b1000);
        tick();
        check("pm2_we", {3'b0, bus_if.cpsr_we}, 4'd1);
        check("pm2_d",  bus_if.cpsr_d,          4'b0110);
        drive(1'b0, 1'b0, AL, 4'b0000, 4'b0000);
        tick();

        // Failed condition and flush
        write_flags(4'b0000);
        tick();
        drive(1'b1, 1'b0, EQ, 4'b1111, 4'b1111);
        #1;
        check("fc_cond_ex", {3'b0, bus_if.cond_ex}, 4'd0);
        tick();
        check("fc_we", {3'b0, bus_if.cpsr_we}, 4'd0);
        check("fc_d",  bus_if.cpsr_d,          4'b0000);
        drive(1'b1, 1'b1, AL, 4'b1111, 4'b1111);
        #1;
        check("fl_cond_ex", {3'b0, bus_if.cond_ex}, 4'd1);
        tick();
        check("fl_we", {3'b0, bus_if.cpsr_we}, 4'd0);
        check("fl_d",  bus_if.cpsr_d,          4'b0000);
        drive(1'b1, 1'b0, AL, 4'b0000, 4'b1111);
        tick();
        check("nomask_we", {3'b0, bus_if.cpsr_we}, 4'd0);
        check("nomask_q",  bus_if.cpsr_q,          4'b0000);

        // Reset while a write is being presented
        drive(1'b1, 1'b0, AL, 4'b1111, 4'b1010);
        tick();
        check("rw_we", {3'b0, bus_if.cpsr_we}, 4'd1);
        check("rw_d",  bus_if.cpsr_d,          4'b1010);
        drive(1'b0, 1'b0, AL, 4'b0000, 4'b0000);
        rst_n = 1'b0;
        tick();
        check("rw_drop_we", {3'b0, bus_if.cpsr_we},     4'd0);
        check("rw_ready",   {3'b0, bus_if.instr_ready}, 4'd0);
        check("rw_cpsr_q",  bus_if.cpsr_q,              4'b1010);
        rst_n = 1'b1;
        tick();
        check("rw_init_we", {3'b0, bus_if.cpsr_we}, 4'd1);
        check("rw_init_d",  bus_if.cpsr_d,          4'b0000);
        tick();
        check("rw_init_q",     bus_if.cpsr_q,              4'b0000);
        check("rw_init_ready", {3'b0, bus_if.instr_ready}, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpsr_flag_writer.md
# cpsr_flag_writer

Producer side of the CPSR flag register. It evaluates the ARMv4 condition field of the execute-stage instruction against the current NZCV flags, and merges the ALU's new flags under a per-flag write mask. It drives the CPSR write port (`datain`/`CPSR_WE`) and reads the flags back through the CPSR's registered `dataout`, with a one-entry bypass for the write still in flight. After reset it also initialises the CPSR contents.

## Interface
- `bus`, default 4: flag width; bit 3=N, 2=Z, 1=C, 0=V.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  execute-stage instruction present.
- `flush`  in  1  kill the execute-stage instruction this cycle.
- `cond`  in  4  instruction condition field [31:28].
- `flag_wmask`  in  bus  per-flag update enable; all zero when the S bit is clear.
- `alu_flags`  in  bus  NZCV produced by ALU/shifter.
- `cpsr_q`  in  bus  CPSR `dataout`.
- `instr_ready`  out  1  block accepts instructions.
- `cond_ex`  out  1  condition passed (combinational).
- `flags_cur`  out  bus  architecturally current flags, including bypass.
- `cpsr_d`  out  bus  to CPSR `datain`, registered.
- `cpsr_we`  out  1  to CPSR `CPSR_WE`, registered.

## Operation
- **Reset and clock.** One clock, `clk`. Reset is synchronous and active-low (`rst_n`).
- **FSM states:**
  - RESET: while `rst_n`=0. `cpsr_we`=0, `cpsr_d`=0, `instr_ready`=0.
  - INIT: first cycle after `rst_n` rises. Drives `cpsr_we`=1, `cpsr_d`=0. `instr_ready`=0.
  - RUN: permanent until the next reset.
- **Current flags.** `flags_cur` = `cpsr_we` ? `cpsr_d` : `cpsr_q`. This is the bypass for the write currently presented to the CPSR.
- **Condition evaluation.** `cond_ex` evaluates `cond` on `flags_cur`:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; NV (1111) 0.
- **Accept.** An instruction is accepted when `instr_ready` & `instr_valid` & !`flush`.
- **Write.** An accepted instruction with `cond_ex`=1 and `flag_wmask`≠0 causes, next cycle:
  - `cpsr_we`=1.
  - `cpsr_d` = (`alu_flags` & mask) | (`flags_cur` & ~mask).
- **No write.** Every other case gives `cpsr_we`=0 next cycle, and `cpsr_d` holds its previous value.
- **Flush.** `flush` suppresses the write even if `cond_ex`=1. `cond_ex` itself is still driven combinationally.
- **Reset mid-operation.** A pending `cpsr_we` is dropped. The INIT write of 0 then overwrites the CPSR.

## Timing
- **Write latency.** Instruction accepted in cycle t:
  - `cpsr_we`/`cpsr_d` valid in t+1.
  - CPSR captures on the falling edge of t+1.
  - `cpsr_q` shows the new value in t+2.
- **Back-to-back (t+1).** An instruction at t+1 sees the t write via the bypass. An instruction at t+2 sees it via `cpsr_q`.
- **Consecutive writes.** Each merge uses the bypassed value, so partial masks chain correctly. No stall is ever required.
- **Reset values.** `cpsr_we`=0, `cpsr_d`=0, `instr_ready`=0. `cond_ex` and `flags_cur` follow the inputs.
- **Ready.** `instr_ready` rises in the cycle after INIT, at the second rising edge after reset release.
- **`cpsr_q` before the first write.** `cpsr_q` is undefined until the INIT write has propagated, i.e. until the first RUN cycle.

## Structure
- **Package `cpsr_pkg`:**
  - `cond_e` enum (EQ=0 … AL=14, NV=15).
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `state_e` (RESET, INIT, RUN).
- **Sub-module `cond_check`:** purely combinational.
  - Inputs: `cond` and `flags`.
  - Output: `pass`.
  - Reused by the branch unit.
- **Top level:** the FSM, the merge logic, the output registers and the bypass mux.

## Test plan
- **Reset/init:** hold `rst_n`=0 for 3 cycles, then release.
  - `cpsr_we`=1 with `cpsr_d`=0000 exactly one cycle after release.
  - `instr_ready`=1 from the following cycle.
- **Condition sweep:** with `flags_cur`=0100 (Z), cover all 16 codes.
  - Pass: EQ, CC, PL, VC, LS, GE, LE, AL.
  - Fail: the rest, including NV.
- **Back-to-back bypass:** starting from CPSR=0000:
  - Cycle t: SUBS, `alu_flags`=0110, mask 1111.
  - Cycle t+1: BEQ, which passes via the bypass (`flags_cur`=0110).
  - Cycle t+2: `cpsr_q`=0110.
- **Partial mask chain:** starting from flags 1001:
  - First write `alu_flags`=0110, mask 1110 → `cpsr_d`=0111.
  - Next cycle, `alu_flags`=1000, mask 0001 → `cpsr_d`=0110.
- **Failed condition / flush:**
  - From flags 0000, an EQ instruction with mask 1111 gives no write.
  - An AL instruction with `flush`=1 gives no write.
  - `cpsr_we` stays 0 in both cases.
- **Reset mid-write:**
  - Assert `rst_n`=0 in the cycle `cpsr_we`=1 → `cpsr_we`=0 the next cycle.
  - After release, the INIT write of 0000 occurs.
